adsr_envelope: RTL and testbench

Per-voice amplitude envelope generator between the sine-table BRAM output and the PWM stage. Consumes `gate`/`trigger` from the note decoder and runs an attack/decay/sustain/release state machine clocked by an internal tick divider. Scales each 8-bit offset-binary sample by the current envelope level, so key press and release fade in and out instead of clicking.

---
 rtl/adsr_envelope.sv | 159 +++++++++++++++
 tb/tb_adsr_envelope.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope; scales an offset-binary sample by the current level.
// Latency: state/env change one edge after the input is sampled, and sample_out is registered one cycle after sample_in.
// Backpressure: none; this is a free-running streaming stage that accepts a new sample every cycle.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-low reset
//   gate_in           key held
//   trigger_in        one-cycle new-note pulse (retriggers ATTACK from the current level)
//   attack_step_in    level increment per tick in ATTACK
//   decay_step_in     level decrement per tick in DECAY
//   sustain_level_in  SUSTAIN target level (tracked live)
//   release_step_in   level decrement per tick in RELEASE
//   sample_in         raw wavetable sample, offset-binary
//   sample_out        enveloped sample, registered
//   env_out           current envelope level, registered
//   state_out         IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active_out        high while state is not IDLE
module adsr_envelope #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ENV_WIDTH    = 16,
  parameter int TICK_DIV     = 1000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    gate_in,
  input  logic                    trigger_in,
  input  logic [ENV_WIDTH-1:0]    attack_step_in,
  input  logic [ENV_WIDTH-1:0]    decay_step_in,
  input  logic [ENV_WIDTH-1:0]    sustain_level_in,
  input  logic [ENV_WIDTH-1:0]    release_step_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic [ENV_WIDTH-1:0]    env_out,
  output logic [2:0]              state_out,
  output logic                    active_out
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW    = SAMPLE_WIDTH + ENV_WIDTH + 1;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ENV_WIDTH-1:0]    ENV_MAX  = '1;
  localparam logic [SAMPLE_WIDTH-1:0] MID      = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [ENV_WIDTH-1:0]    env_q, env_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    tick;
  logic [ENV_WIDTH:0]      att_sum;
  logic [ENV_WIDTH:0]      dec_floor;
  logic signed [PW-1:0]    s_wide, e_wide, prod;

  // Free-running divider; never restarted by note events so tick phase is stable.
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      env_q    <= '0;
      cnt_q    <= '0;
      sample_q <= MID;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
    end
  end

  // Next-state / next-level logic. Note events override level arithmetic,
  // so a tick that coincides with a state-changing event leaves env untouched.
  always_comb begin
    state_d   = state_q;
    env_d     = env_q;
    // One bit wider so overflow past ENV_MAX and sustain+step are exact.
    att_sum   = {1'b0, env_q} + {1'b0, attack_step_in};
    dec_floor = {1'b0, sustain_level_in} + {1'b0, decay_step_in};

    if (trigger_in) begin
      state_d = S_ATTACK;
    end else if (gate_in && (state_q == S_IDLE || state_q == S_RELEASE)) begin
      state_d = S_ATTACK;
    end else if (!gate_in && (state_q == S_ATTACK || state_q == S_DECAY ||
                              state_q == S_SUSTAIN)) begin
      state_d = S_RELEASE;
    end else begin
      case (state_q)
        S_IDLE: env_d = '0;
        S_ATTACK: begin
          // Zero step completes the phase rather than holding forever.
          if (tick) begin
            if (attack_step_in == '0 || att_sum >= {1'b0, ENV_MAX}) begin
              env_d   = ENV_MAX;
              state_d = S_DECAY;
            end else begin
              env_d = att_sum[ENV_WIDTH-1:0];
            end
          end
        end
        S_DECAY: begin
          if (tick) begin
            if (decay_step_in == '0 || {1'b0, env_q} <= dec_floor) begin
              env_d   = sustain_level_in;
              state_d = S_SUSTAIN;
            end else begin
              env_d = env_q - decay_step_in;
            end
          end
        end
        S_SUSTAIN: begin
          if (tick) env_d = sustain_level_in;
        end
        S_RELEASE: begin
          if (tick) begin
            if (release_step_in == '0 || env_q <= release_step_in) begin
              env_d   = '0;
              state_d = S_IDLE;
            end else begin
              env_d = env_q - release_step_in;
            end
          end
        end
        default: begin
          env_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Signed scaling around the midpoint; the arithmetic shift floors toward
  // -inf, and env < 1.0 keeps the result inside the sample range.
  always_comb begin
    s_wide   = $signed(PW'(sample_in)) - $signed(PW'(MID));
    e_wide   = $signed(PW'(env_q));
    prod     = s_wide * e_wide;
    sample_d = SAMPLE_WIDTH'((prod >>> ENV_WIDTH) + $signed(PW'(MID)));
  end

  // Output logic
  always_comb begin
    state_out  = state_q;
    env_out    = env_q;
    sample_out = sample_q;
    active_out = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed bench for adsr_envelope with TICK_DIV=4.
// Inputs are driven and outputs sampled on the falling clock edge.
// A small divider model tracks which rising edges carry a tick.
module tb_adsr_envelope;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        gate_in;
  logic        trigger_in;
  logic [15:0] attack_step_in;
  logic [15:0] decay_step_in;
  logic [15:0] sustain_level_in;
  logic [15:0] release_step_in;
  logic [7:0]  sample_in;
  logic [7:0]  sample_out;
  logic [15:0] env_out;
  logic [2:0]  state_out;
  logic        active_out;

  int checks = 0;
  int errors = 0;

  int cnt_m = 0;
  bit tick_seen = 1'b0;

  adsr_envelope #(
    .SAMPLE_WIDTH(8),
    .ENV_WIDTH(16),
    .TICK_DIV(4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .gate_in(gate_in),
    .trigger_in(trigger_in),
    .attack_step_in(attack_step_in),
    .decay_step_in(decay_step_in),
    .sustain_level_in(sustain_level_in),
    .release_step_in(release_step_in),
    .sample_in(sample_in),
    .sample_out(sample_out),
    .env_out(env_out),
    .state_out(state_out),
    .active_out(active_out)
  );

  always #5 clk_in = ~clk_in;

  // Divider model: a tick is sampled on an edge where the counter was 3.
  always @(posedge clk_in) begin
    tick_seen <= rst_in && (cnt_m == 3);
    if (!rst_in)         cnt_m <= 0;
    else if (cnt_m == 3) cnt_m <= 0;
    else                 cnt_m <= cnt_m + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows the next tick-carrying rising edge.
  task automatic to_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!tick_seen && n < 8);
    if (!tick_seen) begin
      checks++;
      errors++;
      $error("FAIL to_tick: observed no tick in %0d cycles expected tick within 4", n);
    end
  endtask

  initial begin
    rst_in           = 1'b0;
    gate_in          = 1'b0;
    trigger_in       = 1'b0;
    attack_step_in   = 16'h4000;
    decay_step_in    = 16'h1000;
    sustain_level_in = 16'h8000;
    release_step_in  = 16'h2000;
    sample_in        = 8'd255;

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_state",  state_out,  3'd0);
    chk("rst_env",    env_out,    16'h0000);
    chk("rst_active", active_out, 1'b0);
    chk("rst_sample", sample_out, 8'd128);

    // Idle with full-scale input stays silent
    rst_in = 1'b1;
    repeat (10) @(negedge clk_in);
    chk("idle_state",  state_out,  3'd0);
    chk("idle_env",    env_out,    16'h0000);
    chk("idle_sample", sample_out, 8'd128);

    // Attack ramp
    to_tick();
    gate_in    = 1'b1;
    trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("atk_enter_state",  state_out,  3'd1);
    chk("atk_enter_env",    env_out,    16'h0000);
    chk("atk_enter_active", active_out, 1'b1);
    to_tick(); chk("atk_t1", env_out, 16'h4000);
    to_tick(); chk("atk_t2", env_out, 16'h8000);
    to_tick(); chk("atk_t3", env_out, 16'hC000);
    chk("atk_t3_state", state_out, 3'd1);
    to_tick(); chk("atk_t4", env_out, 16'hFFFF);
    chk("atk_t4_state", state_out, 3'd2);

    // Scaling at env 0xFFFF
    sample_in = 8'd255; @(negedge clk_in); chk("scale_ffff_255", sample_out, 8'd254);
    sample_in = 8'd0;   @(negedge clk_in); chk("scale_ffff_0",   sample_out, 8'd0);
    sample_in = 8'd128; @(negedge clk_in); chk("scale_ffff_128", sample_out, 8'd128);

    // Decay down to sustain
    for (int i = 1; i <= 7; i++) begin
      to_tick();
      chk("dec_env",   env_out,   32'h0000FFFF - 32'(i) * 32'h1000);
      chk("dec_state", state_out, 3'd2);
    end
    to_tick();
    chk("sus_env",   env_out,   16'h8000);
    chk("sus_state", state_out, 3'd3);

    // Scaling at env 0x8000
    sample_in = 8'd255; @(negedge clk_in); chk("scale_8000_255", sample_out, 8'd191);

    // Release
    gate_in = 1'b0;
    @(negedge clk_in);
    chk("rel_enter_state", state_out, 3'd4);
    chk("rel_enter_env",   env_out,   16'h8000);
    to_tick(); chk("rel_t1", env_out, 16'h6000);
    to_tick(); chk("rel_t2", env_out, 16'h4000);
    to_tick(); chk("rel_t3", env_out, 16'h2000);
    chk("rel_t3_active", active_out, 1'b1);
    to_tick(); chk("rel_t4", env_out, 16'h0000);
    chk("rel_t4_state",  state_out,  3'd0);
    chk("rel_t4_active", active_out, 1'b0);

    // Retrigger mid-release keeps the level
    attack_step_in = 16'h7000;
    gate_in        = 1'b1;
    trigger_in     = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("rt_atk_state", state_out, 3'd1);
    to_tick(); chk("rt_atk_env", env_out, 16'h7000);
    gate_in = 1'b0;
    @(negedge clk_in);
    chk("rt_rel_state", state_out, 3'd4);
    chk("rt_rel_env",   env_out,   16'h7000);
    to_tick(); chk("rt_rel_t1", env_out, 16'h5000);
    attack_step_in = 16'h0000;
    gate_in        = 1'b1;
    trigger_in     = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("rt_state", state_out, 3'd1);
    chk("rt_env",   env_out,   16'h5000);
    to_tick();
    chk("zero_atk_env",   env_out,   16'hFFFF);
    chk("zero_atk_state", state_out, 3'd2);

    // Trigger coinciding with gate fall: ATTACK wins, then RELEASE
    gate_in    = 1'b0;
    trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("trig_fall_state", state_out, 3'd1);
    @(negedge clk_in);
    chk("trig_fall_next_state", state_out, 3'd4);
    chk("trig_fall_env",        env_out,   16'hFFFF);

    // Reset pulsed mid-attack, on an edge that also carries a tick
    attack_step_in = 16'h4000;
    gate_in        = 1'b1;
    trigger_in     = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("pre_rst_state", state_out, 3'd1);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("mid_rst_state",  state_out,  3'd0);
    chk("mid_rst_env",    env_out,    16'h0000);
    chk("mid_rst_sample", sample_out, 8'd128);
    chk("mid_rst_active", active_out, 1'b0);

    // Counter restarts: first tick lands 4 cycles after release
    rst_in     = 1'b1;
    trigger_in = 1'b1;
    @(negedge clk_in);
    trigger_in = 1'b0;
    chk("post_rst_state", state_out, 3'd1);
    repeat (2) @(negedge clk_in);
    chk("post_rst_env_c3", env_out, 16'h0000);
    @(negedge clk_in);
    chk("post_rst_env_c4", env_out, 16'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
